// File: rtl/router_pkg.sv
// Shared router/framer definitions: bus widths, port count, header layout,
// framer FSM encoding and destination identifiers.
package router_pkg;

  localparam int unsigned UWIDTH    = 8;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned DEST_W    = 2;
  localparam int unsigned MAX_LEN   = (32'd1 << LEN_W) - 32'd1;
  localparam int unsigned NUM_PORTS = 3;

  // Destination port identifiers
  localparam logic [DEST_W-1:0] TS1 = 2'd0;
  localparam logic [DEST_W-1:0] TS2 = 2'd1;
  localparam logic [DEST_W-1:0] TS3 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4
  } state_t;

  // Header byte layout: LEN in [7:2], DEST in [1:0]
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DEST_W-1:0] dest;
  } header_t;

  function automatic logic [UWIDTH-1:0] make_header(input logic [DEST_W-1:0] dest,
                                                    input logic [LEN_W-1:0]  len);
    header_t h;
    h.len  = len;
    h.dest = dest;
    return UWIDTH'(h);
  endfunction

endpackage

// File: rtl/packet_framer_if.sv
// Host/router-facing bundle of the packet framer.
//   req_*            : routing request handshake (dest, length)
//   pl_*             : payload byte stream handshake
//   stop_packet_send : router back-pressure
//   packet_valid_o / packet_out : framed byte stream toward the router
// master = host/router side, slave = framer side.
interface packet_framer_if import router_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic [DEST_W-1:0] req_dest;
  logic [LEN_W-1:0]  req_len;
  logic              pl_valid;
  logic              pl_ready;
  logic [UWIDTH-1:0] pl_data;
  logic              stop_packet_send;
  logic              packet_valid_o;
  logic [UWIDTH-1:0] packet_out;

  modport master (
    output req_valid, req_dest, req_len, pl_valid, pl_data, stop_packet_send,
    input  req_ready, pl_ready, packet_valid_o, packet_out
  );

  modport slave (
    input  req_valid, req_dest, req_len, pl_valid, pl_data, stop_packet_send,
    output req_ready, pl_ready, packet_valid_o, packet_out
  );

endinterface

// File: rtl/packet_buffer.sv
// Payload store for one packet: MAX_LEN x UWIDTH flops, one write port,
// combinational read port. Storage is not reset.
//   clk              : write clock
//   we/waddr/wdata   : write port
//   raddr/rdata      : combinational read port
module packet_buffer
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [UWIDTH-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [UWIDTH-1:0] rdata
);

  logic [UWIDTH-1:0] mem [MAX_LEN];

  // Write port; address MAX_LEN is outside the array and ignored
  always_ff @(posedge clk) begin
    if (we && (waddr < LEN_W'(MAX_LEN))) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; the framer may present raddr==len (==MAX_LEN) while emitting parity
  assign rdata = (raddr < LEN_W'(MAX_LEN)) ? mem[raddr] : '0;

endmodule

// File: rtl/packet_framer.sv
// Host-side packet source: accepts a routing request and its payload,
// buffers the whole payload, then emits header, payload and parity bytes
// as one contiguous packet honouring router back-pressure.
//   clk1      : clock
//   rst       : synchronous active-high reset
//   bus       : request / payload / router stream (slave modport)
//   busy      : high whenever the FSM is outside IDLE
//   err_pulse : one-cycle pulse after a rejected request
module packet_framer
  import router_pkg::*;
(
  input  logic           clk1,
  input  logic           rst,
  packet_framer_if.slave bus,
  output logic           busy,
  output logic           err_pulse
);

  localparam logic [DEST_W-1:0] DEST_LIMIT = DEST_W'(NUM_PORTS);

  state_t            state;
  logic [DEST_W-1:0] dest_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  rcnt;
  logic [UWIDTH-1:0] parity;

  logic              pl_accept_c;
  logic              xfer_c;
  logic [UWIDTH-1:0] rdata;

  assign pl_accept_c = (state == S_LOAD) && bus.pl_valid && bus.pl_ready;
  assign xfer_c      = bus.packet_valid_o && !bus.stop_packet_send;

  packet_buffer u_buf (
    .clk   (clk1),
    .we    (pl_accept_c),
    .waddr (wcnt),
    .wdata (bus.pl_data),
    .raddr (rcnt),
    .rdata (rdata)
  );

  // Framer FSM with registered handshake and stream outputs
  always_ff @(posedge clk1) begin
    err_pulse <= 1'b0;
    if (rst) begin
      state              <= S_IDLE;
      dest_r             <= '0;
      len_r              <= '0;
      wcnt               <= '0;
      rcnt               <= '0;
      parity             <= '0;
      busy               <= 1'b0;
      bus.req_ready      <= 1'b1;
      bus.pl_ready       <= 1'b0;
      bus.packet_valid_o <= 1'b0;
      bus.packet_out     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            if ((bus.req_dest >= DEST_LIMIT) || (bus.req_len == '0)) begin
              err_pulse <= 1'b1;
            end else begin
              dest_r        <= bus.req_dest;
              len_r         <= bus.req_len;
              wcnt          <= '0;
              rcnt          <= '0;
              parity        <= make_header(bus.req_dest, bus.req_len);
              busy          <= 1'b1;
              bus.req_ready <= 1'b0;
              bus.pl_ready  <= 1'b1;
              state         <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (pl_accept_c) begin
            parity <= parity ^ bus.pl_data;
            wcnt   <= wcnt + LEN_W'(1);
            // Last byte: header goes out on the very next cycle
            if (wcnt == (len_r - LEN_W'(1))) begin
              bus.pl_ready       <= 1'b0;
              bus.packet_out     <= make_header(dest_r, len_r);
              bus.packet_valid_o <= 1'b1;
              state              <= S_HEADER;
            end
          end
        end

        S_HEADER: begin
          if (xfer_c) begin
            bus.packet_out <= rdata;
            rcnt           <= LEN_W'(1);
            state          <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (xfer_c) begin
            if (rcnt == len_r) begin
              bus.packet_out <= parity;
              state          <= S_PARITY;
            end else begin
              bus.packet_out <= rdata;
              rcnt           <= rcnt + LEN_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (xfer_c) begin
            bus.packet_valid_o <= 1'b0;
            bus.packet_out     <= '0;
            busy               <= 1'b0;
            bus.req_ready      <= 1'b1;
            state              <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
